// File: rtl/arm_mem_pkg.sv
// Shared types and defaults for the ARM memory stage and its SRAM controller.
// Holds the access FSM state type, the default base address and wait-state
// count, and the width of the external asynchronous SRAM data bus.
package arm_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } mem_state_t;

    localparam logic [31:0] DEF_BASE_ADDR   = 32'd1024;
    localparam int          DEF_WAIT_CYCLES = 4;
    localparam int          DEF_SRAM_AW     = 18;
    localparam int          SRAM_DW         = 16;

endpackage

// File: rtl/sram_wait_counter.sv
// Wait-state counter for one SRAM half-word access phase.
// Ports: clk, rst (async, active high), load (restart on phase entry),
//        done (high during the last cycle of the phase).
module sram_wait_counter
    import arm_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    logic [CW-1:0] cnt;

    // Loaded on the edge that enters a phase, so the first cycle of the
    // phase already sees WAIT_CYCLES-1 and the count hits zero on its last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(WAIT_CYCLES - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// ARM pipeline memory stage: turns one 32-bit load/store from the EXE/MEM
// register into two half-word accesses on a 16-bit asynchronous SRAM.
// Ports: mem_r_en/mem_w_en/alu_result/st_val in; mem_read_value, ready
//        (freeze = ~ready), sram_addr/sram_wdata/sram_we_n/sram_rdata, addr_err.
// Optional MEM_ADDR_CHECK_EN: out-of-range accesses skip the SRAM, loads
// return 0 and addr_err sets sticky; otherwise addresses truncate.
module mem_stage_sram_ctrl
    import arm_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter int          WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int          SRAM_AW     = DEF_SRAM_AW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_r_en,
    input  logic               mem_w_en,
    input  logic [31:0]        alu_result,
    input  logic [31:0]        st_val,
    output logic [31:0]        mem_read_value,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_wdata,
    input  logic [SRAM_DW-1:0] sram_rdata,
    output logic               sram_we_n,
    output logic               addr_err
);

    mem_state_t         state;
    logic               req;
    logic               oor;
    logic               wait_done;
    logic               cnt_load;
    logic               is_wr_q;
    logic [31:0]        offset;
    logic [SRAM_AW-2:0] word_idx;
    logic [SRAM_DW-1:0] st_hi_q;
    logic [SRAM_DW-1:0] rdata_lo_q;
    logic               unused_offset;

    assign req      = mem_r_en | mem_w_en;
    assign offset   = alu_result - BASE_ADDR;
    assign word_idx = offset[SRAM_AW:2];

`ifdef MEM_ADDR_CHECK_EN
    // word >= 2**(SRAM_AW-1) is the same as any offset bit above SRAM_AW set.
    assign oor           = (alu_result < BASE_ADDR) || (offset[31:SRAM_AW+1] != '0);
    assign unused_offset = &{1'b0, offset[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_err <= 1'b0;
        end else if (state == IDLE && req && oor) begin
            addr_err <= 1'b1;
        end
    end
`else
    assign oor           = 1'b0;
    assign addr_err      = 1'b0;
    assign unused_offset = &{1'b0, offset[31:SRAM_AW+1], offset[1:0]};
`endif

    assign ready    = (state == IDLE && !req) || (state == DONE);
    assign cnt_load = (state == IDLE && req && !oor) || (state == LO && wait_done);

    sram_wait_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load),
        .done (wait_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            mem_read_value <= '0;
            sram_addr      <= '0;
            sram_wdata     <= '0;
            sram_we_n      <= 1'b1;
            is_wr_q        <= 1'b0;
            st_hi_q        <= '0;
            rdata_lo_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        // A store wins when both enables are set.
                        is_wr_q <= mem_w_en;
                        if (oor) begin
                            state <= DONE;
                            if (!mem_w_en) begin
                                mem_read_value <= '0;
                            end
                        end else begin
                            state      <= LO;
                            sram_addr  <= {word_idx, 1'b0};
                            sram_wdata <= st_val[15:0];
                            st_hi_q    <= st_val[31:16];
                            sram_we_n  <= ~mem_w_en;
                        end
                    end
                end
                LO: begin
                    if (wait_done) begin
                        state      <= HI;
                        sram_addr  <= {sram_addr[SRAM_AW-1:1], 1'b1};
                        sram_wdata <= st_hi_q;
                        if (!is_wr_q) begin
                            rdata_lo_q <= sram_rdata;
                        end
                    end
                end
                HI: begin
                    if (wait_done) begin
                        state     <= DONE;
                        sram_we_n <= 1'b1;
                        if (!is_wr_q) begin
                            mem_read_value <= {sram_rdata, rdata_lo_q};
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
module tb_mem_stage_sram_ctrl;

    localparam logic [31:0] BASE = 32'd1024;
    localparam int          W    = 4;
    localparam int          AW   = 18;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mem_r_en = 1'b0;
    logic          mem_w_en = 1'b0;
    logic [31:0]   alu_result = '0;
    logic [31:0]   st_val = '0;
    logic [31:0]   mem_read_value;
    logic          ready;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_wdata;
    logic [15:0]   sram_rdata;
    logic          sram_we_n;
    logic          addr_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Word-level reference memory and expected sticky/output state.
    logic [31:0] exp_word [0:511];
    logic [31:0] exp_rd  = '0;
    logic        exp_err = 1'b0;

    // Behavioural asynchronous SRAM (only the low 1024 half-words modelled).
    logic [15:0] sram_mem [0:1023];
    logic        preloaded = 1'b0;

    function automatic logic [15:0] init_half(input int i);
        return 16'((i * 40503 + 12345) ^ (i << 5));
    endfunction

    always @(posedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < 1024; i++) sram_mem[i] <= init_half(i);
            preloaded <= 1'b1;
        end else if (!sram_we_n) begin
            sram_mem[sram_addr[9:0]] <= sram_wdata;
        end
    end

    assign sram_rdata = sram_mem[sram_addr[9:0]];

    always #5 clk = ~clk;

    mem_stage_sram_ctrl #(
        .BASE_ADDR   (BASE),
        .WAIT_CYCLES (W),
        .SRAM_AW     (AW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_r_en       (mem_r_en),
        .mem_w_en       (mem_w_en),
        .alu_result     (alu_result),
        .st_val         (st_val),
        .mem_read_value (mem_read_value),
        .ready          (ready),
        .sram_addr      (sram_addr),
        .sram_wdata     (sram_wdata),
        .sram_rdata     (sram_rdata),
        .sram_we_n      (sram_we_n),
        .addr_err       (addr_err)
    );

    // One full load/store transaction, checked cycle by cycle against the model.
    task automatic run_access(input logic r, input logic w, input logic [31:0] a,
                              input logic [31:0] v);
        logic [31:0] word;
        logic [31:0] idx;
        logic        oor;
        logic        half;
        logic [17:0] exp_sa;
        logic [15:0] exp_wd;
        logic        fin;
        int          exp_low;
        int          lows;
        int          we_low;
        int          k;
        word = (a - BASE) >> 2;
        idx  = word % 32'd512;
        oor  = 1'b0;
`ifdef MEM_ADDR_CHECK_EN
        oor = (a < BASE) || (word >= 32'h20000);
`endif
        exp_low = oor ? 1 : 2 * W + 1;
        @(negedge clk);
        mem_r_en = r; mem_w_en = w; alu_result = a; st_val = v;
        #1;
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL req_ready a=%h: got %b expected 0", a, ready);
        end
        @(posedge clk); #1;
        // Inputs are scrambled after launch; the access must use latched copies.
        mem_r_en = 1'b0; mem_w_en = 1'b0; alu_result = $urandom; st_val = $urandom;
        lows = 1; we_low = 0; k = 0; fin = 1'b0;
        for (int c = 0; c < 4 * W + 8 && !fin; c++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                fin = 1'b1;
            end else begin
                lows++; k++;
                if (sram_we_n === 1'b0) we_low++;
                if (!oor) begin
                    half   = (k > W);
                    exp_sa = 18'((word % 32'h20000) * 2 + (half ? 1 : 0));
                    exp_wd = half ? v[31:16] : v[15:0];
                    n_checks++;
                    if (sram_addr !== exp_sa) begin
                        n_fail++;
                        $display("FAIL sram_addr a=%h cyc=%0d: got %h expected %h", a, k, sram_addr, exp_sa);
                    end
                    n_checks++;
                    if (sram_we_n !== !w) begin
                        n_fail++;
                        $display("FAIL sram_we_n a=%h cyc=%0d: got %b expected %b", a, k, sram_we_n, !w);
                    end
                    if (w) begin
                        n_checks++;
                        if (sram_wdata !== exp_wd) begin
                            n_fail++;
                            $display("FAIL sram_wdata a=%h cyc=%0d: got %h expected %h", a, k, sram_wdata, exp_wd);
                        end
                    end
                end
            end
        end
        if (oor) begin
            exp_err = 1'b1;
            if (!w) exp_rd = '0;
        end else if (w) begin
            exp_word[idx] = v;
        end else begin
            exp_rd = exp_word[idx];
        end
        n_checks++;
        if (lows != exp_low) begin
            n_fail++;
            $display("FAIL ready_low_cycles a=%h: got %0d expected %0d", a, lows, exp_low);
        end
        n_checks++;
        if (we_low != ((w && !oor) ? 2 * W : 0)) begin
            n_fail++;
            $display("FAIL we_low_cycles a=%h: got %0d expected %0d", a, we_low, (w && !oor) ? 2 * W : 0);
        end
        n_checks++;
        if (mem_read_value !== exp_rd) begin
            n_fail++;
            $display("FAIL read_value a=%h: got %h expected %h", a, mem_read_value, exp_rd);
        end
        n_checks++;
        if (addr_err !== exp_err) begin
            n_fail++;
            $display("FAIL addr_err a=%h: got %b expected %b", a, addr_err, exp_err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({mem_read_value, sram_addr, sram_wdata, sram_we_n, addr_err, ready} !==
            {32'h0, 18'h0, 16'h0, 1'b1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state: got rv=%h sa=%h wd=%h wen=%b err=%b rdy=%b expected 0/0/0/1/0/1",
                     mem_read_value, sram_addr, sram_wdata, sram_we_n, addr_err, ready);
        end
    endtask

    task automatic test_single_store();
        run_access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
    endtask

    task automatic test_load_after_store();
        run_access(1'b1, 1'b0, 32'd1024, 32'h0);
        n_checks++;
        if (mem_read_value !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL load_after_store: got %h expected deadbeef", mem_read_value);
        end
    endtask

    task automatic test_both_enables();
        run_access(1'b1, 1'b1, 32'd1028, 32'h12345678);
        n_checks++;
        if (mem_read_value !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL both_en_value_held: got %h expected deadbeef", mem_read_value);
        end
        run_access(1'b1, 1'b0, 32'd1028, 32'h0);
    endtask

    task automatic test_back_to_back();
        run_access(1'b1, 1'b0, BASE + 32'd40, 32'h0);
        run_access(1'b1, 1'b0, BASE + 32'd44, 32'h0);
    endtask

    // a=0: out of range with the check enabled, a truncated address otherwise.
    task automatic test_low_address();
        run_access(1'b1, 1'b0, 32'd0, 32'h0);
        run_access(1'b1, 1'b0, BASE + 32'd8, 32'h0);
    endtask

    task automatic test_random(input int n);
        int sel;
        for (int i = 0; i < n; i++) begin
            sel = $urandom_range(0, 2);
            run_access(sel != 1, sel != 0,
                       BASE + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3)),
                       $urandom);
        end
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] v;
        v = $urandom;
        @(negedge clk);
        mem_w_en = 1'b1; alu_result = BASE + 32'd8; st_val = v;
        @(posedge clk); #1;
        mem_w_en = 1'b0;
        @(posedge clk); #2;
        n_checks++;
        if (sram_we_n !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_store_we_n: got %b expected 0", sram_we_n);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({sram_we_n, ready, mem_read_value, sram_addr, addr_err} !== {1'b1, 1'b1, 32'h0, 18'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid_access: got wen=%b rdy=%b rv=%h sa=%h err=%b expected 1/1/0/0/0",
                     sram_we_n, ready, mem_read_value, sram_addr, addr_err);
        end
        // Only the low half had a completed write edge before the abort.
        exp_word[2][15:0] = v[15:0];
        exp_rd  = '0;
        exp_err = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %b expected 1", ready);
        end
        run_access(1'b1, 1'b0, BASE + 32'd8, 32'h0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 512; i++) exp_word[i] = {init_half(2 * i + 1), init_half(2 * i)};
        test_reset();
        test_single_store();
        test_load_after_store();
        test_both_enables();
        test_back_to_back();
        test_low_address();
        test_random(40);
        test_reset_mid_access();
        test_random(10);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
